// File: rtl/mock_alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mock_alu_pkg
// Shared opcode type, opcode constants and the latency-class helper used by
// the MockAlu issue controller, its interface and its testbench.
// ---------------------------------------------------------------------------
package mock_alu_pkg;

  typedef logic [5:0] op_t;

  localparam op_t OP_ADD  = 6'h00;
  localparam op_t OP_SUB  = 6'h07;
  localparam op_t OP_AND  = 6'h08;
  localparam op_t OP_OR   = 6'h09;
  localparam op_t OP_XOR  = 6'h0A;
  localparam op_t OP_SLL  = 6'h0B;
  localparam op_t OP_SRL  = 6'h0C;
  localparam op_t OP_SRA  = 6'h0D;
  localparam op_t OP_EQ   = 6'h0E;
  localparam op_t OP_NE   = 6'h0F;
  localparam op_t OP_LT   = 6'h10;
  localparam op_t OP_LTU  = 6'h11;
  localparam op_t OP_GE   = 6'h12;
  localparam op_t OP_GEU  = 6'h13;
  localparam op_t OP_MUL  = 6'h14;
  localparam op_t OP_IDLE = 6'h3F;

  // Only multiply takes the long path; every other code, defined or not,
  // completes after the short ALU latency.
  function automatic int lat_of(op_t op, int alu_lat, int mul_lat);
    return (op == OP_MUL) ? mul_lat : alu_lat;
  endfunction

endpackage

// File: rtl/mock_alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mock_alu_issue_ctrl_if
// Bundles the requester bus, the MockAlu drive/return path, the response
// port and debug state of the issue controller.
//   slave  : the controller (consumes requests, drives ALU and responses)
//   master : the environment (requesters plus the ALU itself)
// Handshake: a request from requester i transfers in the cycle where
// req_valid[i] & req_ready[i] are both high. req_ready is combinational,
// one-hot or zero, and never asserted for a non-valid requester. Responses
// (rsp_valid) have no backpressure and must be taken in the cycle shown.
// ---------------------------------------------------------------------------
interface mock_alu_issue_ctrl_if
  import mock_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*6-1:0]  req_op;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;

  op_t                   alu_op;
  logic [63:0]           alu_a;
  logic [63:0]           alu_b;
  logic [63:0]           alu_out;

  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_data;
  logic                  busy;

  // Debug view of internal state: round-robin pointer and slot reservations.
  logic [ID_W-1:0]       dbg_rr;
  logic [MUL_LAT:1]      dbg_resv;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_out,
    output req_ready, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, busy, dbg_rr, dbg_resv
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_out,
    input  req_ready, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, busy, dbg_rr, dbg_resv
  );
endinterface

// File: rtl/mock_alu_issue_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Searches from the pointer upward, wrapping to 0.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (pointer -> 0)
//   i_req         request vector (already qualified by the caller)
//   o_grant       one-hot grant, combinational
//   o_grant_vld   any grant this cycle
//   o_grant_idx   index of the granted requester
//   o_rr          current pointer
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_vld,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic [ID_W-1:0]    o_rr
);

  logic [ID_W-1:0]    r_rr;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [ID_W-1:0]    w_idx_hi;
  logic [ID_W-1:0]    w_idx_any;

  // Lowest request at or above the pointer wins; if none, wrap around and
  // take the lowest request overall.
  always_comb begin
    w_req_hi  = '0;
    w_idx_hi  = '0;
    w_idx_any = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_hi[i] = i_req[i] && (i >= int'(r_rr));
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_hi[i]) w_idx_hi  = ID_W'(i);
      if (i_req[i])    w_idx_any = ID_W'(i);
    end
    o_grant_vld = |i_req;
    o_grant_idx = (|w_req_hi) ? w_idx_hi : w_idx_any;
    o_grant     = '0;
    if (o_grant_vld) o_grant[o_grant_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr <= '0;
    end else if (o_grant_vld) begin
      r_rr <= (o_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + ID_W'(1);
    end
  end

  assign o_rr = r_rr;

endmodule

// File: rtl/mock_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mock_alu_issue_ctrl
// Shares one MockAlu between NUM_REQ requesters. Each cycle one eligible
// request is granted round-robin and driven into the ALU; a latency-indexed
// tag pipeline returns the result with the requester id when it emerges.
// Ports:
//   clock, reset  sole clock, synchronous active-high reset
//   bus (slave)   requests, ALU drive/return, responses, busy, debug state
// ---------------------------------------------------------------------------
module mock_alu_issue_ctrl
  import mock_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mock_alu_issue_ctrl_if.slave  bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Tag pipeline, index = cycles until the result emerges. Its valid bits
  // are exactly the result-slot reservations, so one vector serves both.
  logic [MUL_LAT:1]   r_tag_v;
  logic [ID_W-1:0]    r_tag_id [MUL_LAT:1];

  logic [MUL_LAT:1]   w_resv_sh;
  logic [ID_W-1:0]    w_id_sh  [MUL_LAT:1];
  logic [MUL_LAT:1]   w_lat_oh [NUM_REQ];
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_rr;
  op_t                w_alu_op;
  logic [63:0]        w_alu_a;
  logic [63:0]        w_alu_b;
  logic [MUL_LAT:1]   w_win_lat_oh;

  // Shift first: the slot retiring this cycle is already free for a new
  // issue in the same cycle.
  always_comb begin
    w_resv_sh[MUL_LAT] = 1'b0;
    w_id_sh[MUL_LAT]   = '0;
    for (int j = 1; j < MUL_LAT; j++) begin
      w_resv_sh[j] = r_tag_v[j+1];
      w_id_sh[j]   = r_tag_id[j+1];
    end
  end

  // A requester is eligible only if the slot its op would land in is free.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 1; j <= MUL_LAT; j++) begin
        w_lat_oh[i][j] = (lat_of(op_t'(bus.req_op[i*6 +: 6]), ALU_LAT, MUL_LAT) == j);
      end
      w_req[i] = bus.req_valid[i] && !(|(w_lat_oh[i] & w_resv_sh)) && !reset;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_req       (w_req),
    .o_grant     (w_grant),
    .o_grant_vld (w_grant_vld),
    .o_grant_idx (w_win),
    .o_rr        (w_rr)
  );

  // Winner's fields go straight to the ALU; idle op and zero operands
  // otherwise.
  always_comb begin
    w_alu_op     = OP_IDLE;
    w_alu_a      = '0;
    w_alu_b      = '0;
    w_win_lat_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_alu_op     = op_t'(bus.req_op[i*6 +: 6]);
        w_alu_a      = bus.req_a[i*64 +: 64];
        w_alu_b      = bus.req_b[i*64 +: 64];
        w_win_lat_oh = w_lat_oh[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int j = 1; j <= MUL_LAT; j++) r_tag_id[j] <= '0;
    end else begin
      for (int j = 1; j <= MUL_LAT; j++) begin
        r_tag_v[j]  <= w_resv_sh[j] | (w_grant_vld & w_win_lat_oh[j]);
        r_tag_id[j] <= (w_grant_vld && w_win_lat_oh[j]) ? w_win : w_id_sh[j];
      end
    end
  end

  // Responses and busy are masked during reset so in-flight work being
  // discarded never shows up, even in the reset cycle itself.
  always_comb begin
    bus.req_ready = w_grant;
    bus.alu_op    = w_alu_op;
    bus.alu_a     = w_alu_a;
    bus.alu_b     = w_alu_b;
    bus.rsp_valid = r_tag_v[1] && !reset;
    bus.rsp_id    = bus.rsp_valid ? r_tag_id[1] : '0;
    bus.rsp_data  = bus.rsp_valid ? bus.alu_out : 64'd0;
    bus.busy      = (|r_tag_v) && !reset;
    bus.dbg_rr    = w_rr;
    bus.dbg_resv  = r_tag_v;
  end

endmodule

// File: tb/tb_mock_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mock_alu_issue_ctrl
// Directed bench for mock_alu_issue_ctrl with a behavioural MockAlu
// (ALU_LAT / MUL_LAT result delay) and a response scoreboard.
// ---------------------------------------------------------------------------
module tb_mock_alu_issue_ctrl;
  import mock_alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ALU_LAT = 2;
  localparam int MUL_LAT = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mock_alu_issue_ctrl_if #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) bus ();

  mock_alu_issue_ctrl #(
    .NUM_REQ (NUM_REQ),
    .ALU_LAT (ALU_LAT),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- behavioural MockAlu ----------------
  op_t         op_h [1:MUL_LAT];
  logic [63:0] a_h  [1:MUL_LAT];
  logic [63:0] b_h  [1:MUL_LAT];

  function automatic logic [63:0] alu_fn(op_t op, logic [63:0] a, logic [63:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return a * b;
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= MUL_LAT; i++) begin
        op_h[i] <= OP_IDLE; a_h[i] <= '0; b_h[i] <= '0;
      end
    end else begin
      op_h[1] <= bus.alu_op; a_h[1] <= bus.alu_a; b_h[1] <= bus.alu_b;
      for (int i = 2; i <= MUL_LAT; i++) begin
        op_h[i] <= op_h[i-1]; a_h[i] <= a_h[i-1]; b_h[i] <= b_h[i-1];
      end
    end
  end

  always_comb begin
    bus.alu_out = '0;
    if (op_h[MUL_LAT] == OP_MUL)
      bus.alu_out = alu_fn(op_h[MUL_LAT], a_h[MUL_LAT], b_h[MUL_LAT]);
    if (op_h[ALU_LAT] != OP_MUL && op_h[ALU_LAT] != OP_IDLE)
      bus.alu_out = alu_fn(op_h[ALU_LAT], a_h[ALU_LAT], b_h[ALU_LAT]);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0)
        check_val("rsp_unexpected", W'(bus.rsp_valid), W'(0));
      else
        check_val("rsp_order", {bus.rsp_id, bus.rsp_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input op_t op,
                         input logic [63:0] a, input logic [63:0] b);
    bus.req_valid[i]       = v;
    bus.req_op[i*6 +: 6]   = op;
    bus.req_a[i*64 +: 64]  = a;
    bus.req_b[i*64 +: 64]  = b;
  endtask

  task automatic clr_all();
    bus.req_valid = '0;
    bus.req_op    = {NUM_REQ{OP_IDLE}};
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [63:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic chk_rsp(input string tag, input logic [ID_W-1:0] id, input logic [63:0] d);
    check_val({tag, "_valid"}, W'(bus.rsp_valid), W'(1));
    check_val({tag, "_id"},    W'(bus.rsp_id),    W'(id));
    check_val({tag, "_data"},  W'(bus.rsp_data),  W'(d));
  endtask

  // XOR stream operands and hand-computed results per requester.
  logic [63:0] xa [4];
  logic [63:0] xb [4];
  logic [63:0] xr [4];
  int          gs [8];

  // ---------------- directed test sequence ----------------
  initial begin
    xa = '{64'h0F, 64'h33, 64'hAA, 64'h1234};
    xb = '{64'hF0, 64'h0F, 64'hFF, 64'h1200};
    xr = '{64'hFF, 64'h3C, 64'h55, 64'h0034};
    gs = '{1, 2, 3, 0, 1, 2, 3, 0};

    // Reset with every requester valid: nothing may be granted.
    rst = 1'b1;
    clr_all();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, OP_ADD, 64'd1, 64'd1);
    @(posedge clk);
    @(posedge clk);
    sample();
    check_val("rst_ready",   W'(bus.req_ready), W'(0));
    check_val("rst_alu_op",  W'(bus.alu_op),    W'(6'h3F));
    check_val("rst_alu_a",   W'(bus.alu_a),     W'(0));
    check_val("rst_alu_b",   W'(bus.alu_b),     W'(0));
    check_val("rst_rsp_v",   W'(bus.rsp_valid), W'(0));
    check_val("rst_rsp_id",  W'(bus.rsp_id),    W'(0));
    check_val("rst_rsp_d",   W'(bus.rsp_data),  W'(0));
    check_val("rst_busy",    W'(bus.busy),      W'(0));
    check_val("rst_rr",      W'(bus.dbg_rr),    W'(0));
    check_val("rst_resv",    W'(bus.dbg_resv),  W'(0));

    // Single ADD 5+7 from req0: response two cycles later.
    next_cycle();
    rst = 1'b0;
    mon_en = 1'b1;
    clr_all();
    set_req(0, 1'b1, OP_ADD, 64'd5, 64'd7);
    push_exp(2'd0, 64'd12);
    sample();
    check_val("add_ready",  W'(bus.req_ready), W'(4'b0001));
    check_val("add_alu_op", W'(bus.alu_op),    W'(OP_ADD));
    check_val("add_alu_a",  W'(bus.alu_a),     W'(5));
    check_val("add_alu_b",  W'(bus.alu_b),     W'(7));
    next_cycle();
    clr_all();
    sample();
    check_val("add_rsp_early", W'(bus.rsp_valid), W'(0));
    check_val("add_busy",      W'(bus.busy),      W'(1));
    check_val("add_rr",        W'(bus.dbg_rr),    W'(1));
    next_cycle();
    sample();
    chk_rsp("add_rsp", 2'd0, 64'd12);
    next_cycle();
    sample();
    check_val("add_idle_busy", W'(bus.busy), W'(0));

    // All four requesters stream XORs; pointer starts at 1, wraps 3->0.
    next_cycle();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, OP_XOR, xa[i], xb[i]);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      sample();
      check_val("xor_ready",  W'(bus.req_ready), W'(1) << gs[k]);
      check_val("xor_alu_op", W'(bus.alu_op),    W'(OP_XOR));
      check_val("xor_alu_a",  W'(bus.alu_a),     W'(xa[gs[k]]));
      push_exp(ID_W'(gs[k]), xr[gs[k]]);
    end
    next_cycle();
    clr_all();
    repeat (3) next_cycle();

    // MUL 3*4 from req0, then req1 ADD blocked for one cycle.
    set_req(0, 1'b1, OP_MUL, 64'd3, 64'd4);
    push_exp(2'd0, 64'd12);
    push_exp(2'd1, 64'd123);
    sample();
    check_val("mul_ready",  W'(bus.req_ready), W'(4'b0001));
    check_val("mul_alu_op", W'(bus.alu_op),    W'(OP_MUL));
    next_cycle();
    clr_all();
    next_cycle();
    set_req(1, 1'b1, OP_ADD, 64'd100, 64'd23);
    sample();
    check_val("blk_ready",  W'(bus.req_ready), W'(0));
    check_val("blk_alu_op", W'(bus.alu_op),    W'(6'h3F));
    next_cycle();
    sample();
    check_val("unblk_ready",  W'(bus.req_ready), W'(4'b0010));
    check_val("unblk_alu_op", W'(bus.alu_op),    W'(OP_ADD));
    next_cycle();
    clr_all();
    sample();
    chk_rsp("mul_rsp", 2'd0, 64'd12);
    next_cycle();
    sample();
    chk_rsp("add2_rsp", 2'd1, 64'd123);
    next_cycle();

    // MUL, then two ADDs both blocked, then granted in successive cycles.
    set_req(0, 1'b1, OP_MUL, 64'd6, 64'd7);
    push_exp(2'd0, 64'd42);
    push_exp(2'd1, 64'd3);
    push_exp(2'd2, 64'd30);
    sample();
    check_val("m2_ready", W'(bus.req_ready), W'(4'b0001));
    next_cycle();
    clr_all();
    next_cycle();
    set_req(1, 1'b1, OP_ADD, 64'd1, 64'd2);
    set_req(2, 1'b1, OP_ADD, 64'd10, 64'd20);
    sample();
    check_val("m2_blk_ready",  W'(bus.req_ready), W'(0));
    check_val("m2_blk_alu_op", W'(bus.alu_op),    W'(6'h3F));
    check_val("m2_blk_alu_a",  W'(bus.alu_a),     W'(0));
    next_cycle();
    sample();
    check_val("m2_r1_ready", W'(bus.req_ready), W'(4'b0010));
    next_cycle();
    set_req(1, 1'b0, OP_IDLE, 64'd0, 64'd0);
    sample();
    check_val("m2_r2_ready", W'(bus.req_ready), W'(4'b0100));
    chk_rsp("m2_mul_rsp", 2'd0, 64'd42);
    next_cycle();
    clr_all();
    repeat (3) next_cycle();

    // Blocked ADD is skipped and a MUL behind it wins the same cycle.
    set_req(0, 1'b1, OP_MUL, 64'd5, 64'd9);
    push_exp(2'd0, 64'd45);
    push_exp(2'd1, 64'd42);
    push_exp(2'd2, 64'd121);
    sample();
    check_val("skip_m0_ready", W'(bus.req_ready), W'(4'b0001));
    next_cycle();
    clr_all();
    next_cycle();
    set_req(1, 1'b1, OP_ADD, 64'd40, 64'd2);
    set_req(2, 1'b1, OP_MUL, 64'd11, 64'd11);
    sample();
    check_val("skip_ready",  W'(bus.req_ready), W'(4'b0100));
    check_val("skip_alu_op", W'(bus.alu_op),    W'(OP_MUL));
    check_val("skip_alu_a",  W'(bus.alu_a),     W'(11));
    next_cycle();
    set_req(2, 1'b0, OP_IDLE, 64'd0, 64'd0);
    sample();
    check_val("skip_add_ready", W'(bus.req_ready), W'(4'b0010));
    next_cycle();
    clr_all();
    repeat (4) next_cycle();

    // Undefined opcode returns zero after the ALU latency.
    set_req(3, 1'b1, 6'h20, 64'd5, 64'd5);
    push_exp(2'd3, 64'd0);
    sample();
    check_val("undef_ready",  W'(bus.req_ready), W'(4'b1000));
    check_val("undef_alu_op", W'(bus.alu_op),    W'(6'h20));
    next_cycle();
    clr_all();
    next_cycle();
    sample();
    chk_rsp("undef_rsp", 2'd3, 64'd0);
    next_cycle();

    // Three MULs in flight, one-cycle reset: all discarded.
    set_req(0, 1'b1, OP_MUL, 64'd2, 64'd3);
    sample();
    check_val("fl0_ready", W'(bus.req_ready), W'(4'b0001));
    next_cycle();
    clr_all();
    set_req(1, 1'b1, OP_MUL, 64'd4, 64'd4);
    sample();
    check_val("fl1_ready", W'(bus.req_ready), W'(4'b0010));
    next_cycle();
    clr_all();
    set_req(2, 1'b1, OP_MUL, 64'd5, 64'd5);
    sample();
    check_val("fl2_ready", W'(bus.req_ready), W'(4'b0100));
    check_val("fl2_busy",  W'(bus.busy),      W'(1));
    next_cycle();
    clr_all();
    rst = 1'b1;
    set_req(3, 1'b1, OP_ADD, 64'd1, 64'd1);
    sample();
    check_val("rstmid_ready",  W'(bus.req_ready), W'(0));
    check_val("rstmid_alu_op", W'(bus.alu_op),    W'(6'h3F));
    check_val("rstmid_rsp_v",  W'(bus.rsp_valid), W'(0));
    next_cycle();
    rst = 1'b0;
    clr_all();
    sample();
    check_val("post_rst_rr",   W'(bus.dbg_rr),   W'(0));
    check_val("post_rst_resv", W'(bus.dbg_resv), W'(0));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      sample();
      check_val("post_rst_rsp_v", W'(bus.rsp_valid), W'(0));
      check_val("post_rst_busy",  W'(bus.busy),      W'(0));
    end

    // Fresh work after reset: pointer restarted at 0.
    next_cycle();
    set_req(0, 1'b1, OP_ADD, 64'd8, 64'd9);
    set_req(3, 1'b1, OP_ADD, 64'd1, 64'd1);
    push_exp(2'd0, 64'd17);
    push_exp(2'd3, 64'd2);
    sample();
    check_val("new0_ready", W'(bus.req_ready), W'(4'b0001));
    next_cycle();
    set_req(0, 1'b0, OP_IDLE, 64'd0, 64'd0);
    sample();
    check_val("new3_ready", W'(bus.req_ready), W'(4'b1000));
    next_cycle();
    clr_all();
    sample();
    chk_rsp("new0_rsp", 2'd0, 64'd17);
    check_val("new_busy", W'(bus.busy), W'(1));
    next_cycle();
    sample();
    chk_rsp("new3_rsp", 2'd3, 64'd2);
    next_cycle();
    sample();
    check_val("end_busy", W'(bus.busy), W'(0));
    repeat (2) next_cycle();

    // ---------------- final report ----------------
    check_val("exp_q_empty", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mock_alu_issue_ctrl.md
# mock_alu_issue_ctrl

Issue controller that shares one `MockAlu` between `NUM_REQ` requesters. Each cycle it round-robin arbitrates valid requests and drives one op/operand set into the ALU. It tracks every in-flight op through a latency-indexed tag pipeline and returns each result to its requester with the requester's id. Result-slot reservation guarantees that two ops issued in different cycles never complete in the same cycle, even though ALU ops and multiplies have different latencies.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ALU_LAT`, 2: cycles from `alu_op` driven to `alu_out` valid, for every op except multiply.
- `MUL_LAT`, 4: cycles from `alu_op` driven to `alu_out` valid, for op 6'h14. Must be greater than `ALU_LAT`.
- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_op`  in  NUM_REQ*6  per-requester opcode, packed, requester 0 in LSBs.
- `req_a`, `req_b`  in  NUM_REQ*64 each  per-requester operands, packed.
- `req_ready`  out  NUM_REQ  one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `alu_op`  out  6  to ALU `io_op`.
- `alu_a`, `alu_b`  out  64 each  to ALU `io_a` / `io_b`.
- `alu_out`  in  64  from ALU `io_out`.
- `rsp_valid`  out  1  result valid this cycle.
- `rsp_id`  out  $clog2(NUM_REQ)  requester owning the result.
- `rsp_data`  out  64  result.
- `busy`  out  1  at least one op in flight.

## Operation
- Latency class: op 6'h14 uses MUL_LAT. All other opcodes, including undefined ones, use ALU_LAT. Undefined opcodes return 0 and are issued normally.
- Slot reservation vector `resv[MUL_LAT:1]`:
  - Each cycle it shifts down by one.
  - An issue with latency L sets `resv[L]`.
  - A candidate is eligible only if `resv[L]` is clear after the shift.
- Arbitration:
  - Round-robin pointer `rr`. Search starts at `rr` over requesters with `req_valid & eligible`.
  - The first hit wins. `rr` becomes winner+1 mod NUM_REQ.
  - If there is no winner, `rr` is unchanged.
- `req_ready` is combinational from `req_valid` and state. It is asserted for at most one requester, and only for a valid, eligible one.
- ALU drive:
  - On a grant, `alu_op`/`alu_a`/`alu_b` = the winner's fields in the same cycle.
  - With no grant, `alu_op` = 6'h3F and operands = 0.
- Tag pipeline: depth MUL_LAT, entries `{valid,id}`.
  - It shifts each cycle, and an issue writes its entry at depth L.
  - The entry reaching depth 0 drives `rsp_valid`/`rsp_id`, with `rsp_data = alu_out` in that cycle.
- Responses have no backpressure. Requesters must accept `rsp_valid` unconditionally.
- A multiply never conflicts: no earlier issue can reserve slot MUL_LAT.
- An ALU op is blocked only by a multiply issued exactly MUL_LAT−ALU_LAT cycles earlier. A blocked requester is skipped, and the next eligible requester wins.
- `busy` = OR of tag pipeline valid bits.

## Timing
- Issue at cycle t with latency L means `rsp_valid` is high in cycle t+L, with that op's id and data.
- Throughput is one issue per cycle, absent slot conflicts.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - `alu_op` = 6'h3F, `alu_a` = 0, `alu_b` = 0.
  - `busy` = 0, `rr` = 0, `resv` = 0, tag pipeline cleared.
- Reset mid-operation: all in-flight ops are discarded. No `rsp_valid` is produced for them, even though ALU results still emerge. No grants are issued while `reset` is high.
- Simultaneous retire and issue in the same cycle are allowed. The retiring slot is freed by the shift before the eligibility check.
- `rr` wraps from NUM_REQ−1 to 0.

## Structure
- Package `mock_alu_pkg`:
  - `op_t` (6 bits) and opcode constants: ADD 6'h00, SUB 6'h07, AND 6'h08, OR 6'h09, XOR 6'h0A, shifts 6'h0B–0D, compares 6'h0E–13, MUL 6'h14, IDLE 6'h3F.
  - A `lat_of(op)` function.
- One sub-module, `rr_arbiter`: parameterized NUM_REQ, request vector in, one-hot grant out, pointer update on grant.
- Slot reservation and the tag pipeline stay in the top module.

## Test plan
- Single requester: ADD a=5, b=7 at cycle 10 → `rsp_valid` at cycle 12, `rsp_id`=0, `rsp_data`=12.
- All 4 requesters valid with XOR ops continuously → grants 0,1,2,3,0… one per cycle; responses in issue order with matching ids.
- Req0 MUL a=3, b=4 at cycle t; req1 ADD pending at t+2 → req1 not granted at t+2 (slot t+4 taken), granted at t+3. Responses: MUL=12 at t+4, ADD at t+5.
- MUL at t; req1 ADD and req2 ADD valid at t+2 → neither granted at t+2, `alu_op`=6'h3F. Req1 granted t+3, req2 granted t+4.
- Undefined op 6'h20 → `rsp_data`=0 after ALU_LAT cycles.
- 3 ops in flight, `reset` pulsed one cycle → no `rsp_valid` afterward, `busy`=0. A new ADD issued after reset completes normally.
